// File: rtl/imem_byte_loader.sv
// Serial byte loader for the 512x8 instruction memory, with a registered big-endian
// 32-bit word read port for the fetch path and load status flags.
module imem_byte_loader #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load_start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  byte_last,
    output logic                  byte_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [31:0]           rd_data,
    output logic                  loaded,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic                  aligned,
    output logic                  overflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TWO   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_THREE = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
    logic [ADDR_WIDTH:0]   cnt_r, cnt_s;
    logic                  ovf_r, ovf_s;
    logic                  wr_en_s;
    logic                  byte_ready_r, loaded_r, aligned_r;
    logic [31:0]           rd_data_r;
    logic [7:0]            mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_a1_s, rd_a2_s, rd_a3_s;
    assign rd_a1_s = rd_addr + ADDR_ONE;
    assign rd_a2_s = rd_addr + ADDR_TWO;
    assign rd_a3_s = rd_addr + ADDR_THREE;

    // Next-state, pointer, count and overflow decisions for the load sequencer.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        wr_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_start) begin
                    state_s = ST_LOAD;
                    ptr_s   = '0;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // A restart wins over a byte offered in the same cycle.
                if (load_start) begin
                    ptr_s = '0;
                    cnt_s = '0;
                end else if (byte_valid && byte_ready_r) begin
                    wr_en_s = 1'b1;
                    ptr_s   = ptr_r + ADDR_ONE;
                    cnt_s   = cnt_r + CNT_ONE;
                    if (byte_last || (ptr_r == ADDR_LAST)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (load_start) begin
                    state_s = ST_LOAD;
                    ptr_s   = '0;
                    cnt_s   = '0;
                    ovf_s   = 1'b0;
                end else if (byte_valid) begin
                    ovf_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ptr_s   = '0;
                cnt_s   = '0;
                ovf_s   = 1'b0;
            end
        endcase
    end

    // Sequencer state plus status outputs registered from their next values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            cnt_r        <= '0;
            ovf_r        <= 1'b0;
            byte_ready_r <= 1'b0;
            loaded_r     <= 1'b0;
            aligned_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            cnt_r        <= cnt_s;
            ovf_r        <= ovf_s;
            byte_ready_r <= (state_s == ST_LOAD);
            loaded_r     <= (state_s == ST_DONE);
            aligned_r    <= (state_s == ST_DONE) && (cnt_s[1:0] == 2'b00);
        end
    end

    // Byte array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[ptr_r] <= byte_in;
        end
    end

    // Big-endian word read, addresses wrap; old data is seen on a same-cycle write.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_data_r <= 32'h0000_0000;
        end else begin
            rd_data_r <= {mem_r[rd_addr], mem_r[rd_a1_s], mem_r[rd_a2_s], mem_r[rd_a3_s]};
        end
    end

    assign byte_ready = byte_ready_r;
    assign loaded     = loaded_r;
    assign aligned    = aligned_r;
    assign byte_count = cnt_r;
    assign overflow   = ovf_r;
    assign rd_data    = rd_data_r;

endmodule

// File: tb/tb_imem_byte_loader.sv
// Bench for imem_byte_loader: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural model of the loader.
module tb_imem_byte_loader;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_last = 1'b0;
    logic        byte_ready;
    logic [8:0]  rd_addr = 9'd0;
    logic [31:0] rd_data;
    logic        loaded;
    logic [9:0]  byte_count;
    logic        aligned;
    logic        overflow;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    imem_byte_loader #(.ADDR_WIDTH(9)) dut (
        .clk(clk), .clr(clr), .load_start(load_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .loaded(loaded), .byte_count(byte_count),
        .aligned(aligned), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: loading/done flags, byte count, sticky overflow, memory image.
    bit          m_loading = 1'b0;
    bit          m_done = 1'b0;
    int          m_count = 0;
    bit          m_ovf = 1'b0;
    logic [7:0]  m_mem [512];
    bit          m_written [512];
    logic [31:0] m_rd = 32'h0;
    bit          m_rd_ok = 1'b0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_loading = 1'b0;
            m_done = 1'b0;
            m_count = 0;
            m_ovf = 1'b0;
            m_rd = 32'h0;
            m_rd_ok = 1'b1;
        end else begin
            m_rd_ok = 1'b1;
            for (int k = 0; k < 4; k++) begin
                int a;
                a = (int'(rd_addr) + k) % 512;
                m_rd = {m_rd[23:0], m_mem[a]};
                if (!m_written[a]) m_rd_ok = 1'b0;
            end
            if (m_loading) begin
                if (load_start) begin
                    m_count = 0;
                end else if (byte_valid) begin
                    m_mem[m_count] = byte_in;
                    m_written[m_count] = 1'b1;
                    m_count = m_count + 1;
                    if (byte_last || m_count == 512) begin
                        m_loading = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (m_done) begin
                if (load_start) begin
                    m_done = 1'b0;
                    m_loading = 1'b1;
                    m_count = 0;
                    m_ovf = 1'b0;
                end else if (byte_valid) begin
                    m_ovf = 1'b1;
                end
            end else if (load_start) begin
                m_loading = 1'b1;
                m_count = 0;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("byte_ready", 32'(byte_ready), 32'(m_loading));
            check("loaded", 32'(loaded), 32'(m_done));
            check("byte_count", 32'(byte_count), 32'(m_count));
            check("aligned", 32'(aligned), 32'(m_done && (m_count % 4 == 0)));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (m_rd_ok) check("rd_data", rd_data, m_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        byte_valid = 1'b1;
        byte_in = b;
        byte_last = last;
        tick();
        byte_valid = 1'b0;
        byte_last = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    logic [7:0] prog [8];

    initial begin
        prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
        prog[4] = 8'h00; prog[5] = 8'h22; prog[6] = 8'h18; prog[7] = 8'h20;

        // reset state
        tick(); tick();
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rd", rd_data, 32'h0);
        clr = 1'b0;
        chk_en = 1'b1;

        // small program image
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
        check("p_loaded", 32'(loaded), 32'd1);
        check("p_count", 32'(byte_count), 32'd8);
        check("p_aligned", 32'(aligned), 32'd1);
        rd_addr = 9'd0; tick();
        check("p_word0", rd_data, 32'h8C01_0004);
        rd_addr = 9'd4; tick();
        check("p_word1", rd_data, 32'h0022_1820);

        // valid ignored in IDLE, gapped stream in LOAD
        clr = 1'b1; tick(); clr = 1'b0;
        byte_valid = 1'b1; tick(); tick(); tick(); byte_valid = 1'b0;
        check("idle_count", 32'(byte_count), 32'd0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'hA0 + i), 1'b0);
            tick();
        end
        check("gap_count", 32'(byte_count), 32'd4);

        // full fill without last, then overflow
        pulse_start();
        for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b0);
        check("full_count", 32'(byte_count), 32'd512);
        check("full_ready", 32'(byte_ready), 32'd0);
        check("full_loaded", 32'(loaded), 32'd1);
        send_byte(8'h5A, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        rd_addr = 9'd0; tick();
        check("mem0_kept", 32'(rd_data[31:24]), 32'h00);
        rd_addr = 9'd510; tick();
        check("wrap_word", rd_data, 32'hFEFF_0001);
        pulse_start();
        check("ovf_clear", 32'(overflow), 32'd0);
        check("restart_loaded", 32'(loaded), 32'd0);

        // unaligned image, then abort by reset
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i), i == 5);
        check("u_aligned", 32'(aligned), 32'd0);
        check("u_count", 32'(byte_count), 32'd6);
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b0);
        clr = 1'b1;
        #1;
        check("abort_count", 32'(byte_count), 32'd0);
        check("abort_ready", 32'(byte_ready), 32'd0);
        check("abort_loaded", 32'(loaded), 32'd0);
        tick();
        clr = 1'b0;

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            load_start = ($urandom_range(0, 39) == 0);
            byte_valid = ($urandom_range(0, 1) == 1);
            byte_last  = ($urandom_range(0, 24) == 0);
            byte_in    = 8'($urandom);
            rd_addr    = 9'($urandom);
            clr        = ($urandom_range(0, 599) == 0);
            tick();
        end
        clr = 1'b0; load_start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
